// File: rtl/noc_trace_pkg.sv
// Shared types and field layout for the NoC trace/trigger unit.
package noc_trace_pkg;

  localparam int unsigned TS_W  = 16;
  localparam int unsigned EPW   = 6;
  localparam int unsigned PAY_W = 8;
  localparam int unsigned TW    = 32;

  // Bit offsets of the fields inside a trace word
  localparam int unsigned PAY_LSB  = 0;
  localparam int unsigned EP_LSB   = 8;
  localparam int unsigned TAIL_BIT = 14;
  localparam int unsigned HDR_BIT  = 15;
  localparam int unsigned TS_LSB   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic             hdr;
    logic             tail;
    logic [EPW-1:0]   ep;
    logic [PAY_W-1:0] pay;
  } trace_word_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with a registered head word and valid flag.
module trace_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic         push_ok, pop_ok;
  logic [W-1:0] dout_n;

  // Flags, gated handshakes and the head word as it will look after this edge
  always_comb begin
    empty_c  = (wr_ptr == rd_ptr);
    full_c   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    level_c  = wr_ptr - rd_ptr;
    push_ok  = push && !full_c;
    pop_ok   = pop && !empty_c;
    wr_ptr_n = wr_ptr + (AW+1)'(push_ok);
    rd_ptr_n = rd_ptr + (AW+1)'(pop_ok);
    if (wr_ptr_n == rd_ptr_n) begin
      dout_n = '0;
    end else if (push_ok && (rd_ptr_n == wr_ptr)) begin
      dout_n = din;
    end else begin
      dout_n = mem[rd_ptr_n[AW-1:0]];
    end
  end

  // Storage array; contents are don't-care while the pointers mark it empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointers and registered head/valid
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      dout   <= dout_n;
      valid  <= (wr_ptr_n != rd_ptr_n);
    end
  end

endmodule

// File: rtl/noc_trace_unit.sv
// Passive trigger/trace unit tapping the NoC endpoint flit outputs.
module noc_trace_unit
  import noc_trace_pkg::*;
#(
  parameter int unsigned NE          = 64,
  parameter int unsigned V           = 4,
  parameter int unsigned Fpay        = 32,
  parameter int unsigned Fw          = 2 + V + Fpay,
  parameter int unsigned TRACE_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NE*Fw-1:0] flit_in_all,
  input  logic [NE-1:0]    flit_in_wr_all,
  input  logic             arm,
  input  logic [5:0]       trig_ep,
  input  logic [15:0]      trig_th,
  input  logic [NE-1:0]    cap_mask,
  input  logic             rd_en,
  output logic             trigger,
  output logic [31:0]      trace_signal,
  output logic             trace_valid,
  output logic [1:0]       state_o,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned AW = $clog2(TRACE_DEPTH);

  trace_state_e      state_q, state_n;
  logic [15:0]       hdr_cnt_q, hdr_cnt_n;
  logic [15:0]       drop_q, drop_n;
  logic              trig_q, trig_n;
  logic [TS_W-1:0]   ts_q;

  logic              trig_wr, trig_hdr, trig_tail;
  logic [PAY_W-1:0]  trig_pay;
  logic [NE-1:0]     req;
  logic [EPW-1:0]    sel_ep;
  logic              sel_hdr, sel_tail;
  logic [PAY_W-1:0]  sel_pay;
  logic [7:0]        req_cnt, n_req, n_drop;
  logic [16:0]       drop_sum;
  logic [15:0]       th_eff;
  logic              push, clr_drop, pop_ok;
  trace_word_t       push_word;
  logic [TW-1:0]     fifo_dout;
  logic              fifo_valid, fifo_full_c, fifo_empty_c;
  logic [AW:0]       fifo_level_c;
  logic              unused_flit_bits;

  assign unused_flit_bits = ^flit_in_all;
  assign th_eff = (trig_th == 16'd0) ? 16'd1 : trig_th;
  assign pop_ok = rd_en && !fifo_empty_c;

  // Tap of the trigger endpoint plus lowest-index pick and count of capture requests
  always_comb begin
    trig_wr   = 1'b0;
    trig_hdr  = 1'b0;
    trig_tail = 1'b0;
    trig_pay  = '0;
    sel_ep    = '0;
    sel_hdr   = 1'b0;
    sel_tail  = 1'b0;
    sel_pay   = '0;
    req_cnt   = '0;
    req       = flit_in_wr_all & cap_mask;
    for (int i = 0; i < NE; i++) begin
      if (trig_ep == EPW'(i)) begin
        trig_wr   = flit_in_wr_all[i];
        trig_hdr  = flit_in_all[i*Fw + Fw - 1];
        trig_tail = flit_in_all[i*Fw + Fw - 2];
        trig_pay  = flit_in_all[i*Fw +: PAY_W];
      end
    end
    for (int i = NE - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_ep   = EPW'(i);
        sel_hdr  = flit_in_all[i*Fw + Fw - 1];
        sel_tail = flit_in_all[i*Fw + Fw - 2];
        sel_pay  = flit_in_all[i*Fw +: PAY_W];
      end
    end
    for (int i = 0; i < NE; i++) begin
      req_cnt = req_cnt + 8'(req[i]);
    end
  end

  // Next state, header counting, trigger and capture push
  always_comb begin
    state_n   = state_q;
    hdr_cnt_n = hdr_cnt_q;
    trig_n    = 1'b0;
    push      = 1'b0;
    n_req     = '0;
    clr_drop  = 1'b0;
    push_word = '{ts: ts_q, hdr: sel_hdr, tail: sel_tail, ep: sel_ep, pay: sel_pay};
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_n   = ST_ARMED;
          hdr_cnt_n = '0;
          clr_drop  = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig_wr && trig_hdr) begin
          hdr_cnt_n = hdr_cnt_q + 16'd1;
          if (hdr_cnt_n == th_eff) begin
            trig_n    = 1'b1;
            push      = 1'b1;
            n_req     = 8'd1;
            push_word = '{ts: ts_q, hdr: trig_hdr, tail: trig_tail, ep: trig_ep, pay: trig_pay};
            state_n   = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (req != '0) begin
          push  = 1'b1;
          n_req = req_cnt;
          if (!fifo_full_c && !pop_ok && (fifo_level_c == (AW+1)'(TRACE_DEPTH - 1))) begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (arm && fifo_empty_c) begin
          state_n   = ST_ARMED;
          hdr_cnt_n = '0;
          clr_drop  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Saturating drop accounting: losers of the pick, or everyone when full
  always_comb begin
    n_drop = '0;
    if (push) begin
      n_drop = fifo_full_c ? n_req : (n_req - 8'd1);
    end
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_n   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (clr_drop) begin
      drop_n = '0;
    end
  end

  // State, counters and timestamp registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      drop_q    <= '0;
      trig_q    <= 1'b0;
      ts_q      <= '0;
    end else begin
      state_q   <= state_n;
      hdr_cnt_q <= hdr_cnt_n;
      drop_q    <= drop_n;
      trig_q    <= trig_n;
      ts_q      <= ts_q + TS_W'(1);
    end
  end

  trace_fifo #(
    .W     (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .din     (push_word),
    .pop     (rd_en),
    .dout    (fifo_dout),
    .valid   (fifo_valid),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level_c (fifo_level_c)
  );

  assign trigger      = trig_q;
  assign state_o      = state_q;
  assign drop_cnt     = drop_q;
  assign trace_signal = fifo_dout;
  assign trace_valid  = fifo_valid;

endmodule

// File: tb/tb_noc_trace_unit.sv
// Bench for noc_trace_unit: directed scenarios plus random traffic against a queue model.
module tb_noc_trace_unit;

  localparam int NE    = 64;
  localparam int V     = 4;
  localparam int FPAY  = 32;
  localparam int FW    = 2 + V + FPAY;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [NE*FW-1:0] flit_in_all;
  logic [NE-1:0]    flit_in_wr_all;
  logic             arm;
  logic [5:0]       trig_ep;
  logic [15:0]      trig_th;
  logic [NE-1:0]    cap_mask;
  logic             rd_en;
  logic             trigger;
  logic [31:0]      trace_signal;
  logic             trace_valid;
  logic [1:0]       state_o;
  logic [15:0]      drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  noc_trace_unit #(
    .NE(NE), .V(V), .Fpay(FPAY), .Fw(FW), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flit_in_all(flit_in_all), .flit_in_wr_all(flit_in_wr_all),
    .arm(arm), .trig_ep(trig_ep), .trig_th(trig_th), .cap_mask(cap_mask), .rd_en(rd_en),
    .trigger(trigger), .trace_signal(trace_signal), .trace_valid(trace_valid),
    .state_o(state_o), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state = 0, m_hcnt = 0, m_drop = 0, m_ts = 0;
  bit          m_trig = 0, started = 0;
  logic [31:0] m_q[$];
  int          md_pre, md_first, md_nreq, md_ndrop, md_st0, md_th;
  bit          md_push, md_pop;
  logic [31:0] md_w;

  function automatic logic [31:0] mword(input int ep);
    return {16'(m_ts), flit_in_all[ep*FW + FW - 1], flit_in_all[ep*FW + FW - 2],
            6'(ep), flit_in_all[ep*FW +: 8]};
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_state = 0; m_hcnt = 0; m_drop = 0; m_ts = 0; m_trig = 0;
      m_q.delete();
    end else begin
      md_pre  = m_q.size();
      md_pop  = rd_en && (md_pre > 0);
      md_push = 0;
      md_nreq = 0;
      md_st0  = m_state;
      m_trig  = 0;
      md_th   = (trig_th == 0) ? 1 : int'(trig_th);
      if (md_st0 == 0) begin
        if (arm) begin m_state = 1; m_hcnt = 0; m_drop = 0; end
      end else if (md_st0 == 1) begin
        if (int'(trig_ep) < NE && flit_in_wr_all[trig_ep] && flit_in_all[int'(trig_ep)*FW + FW - 1]) begin
          m_hcnt = (m_hcnt + 1) % 65536;
          if (m_hcnt == md_th) begin
            m_trig = 1; md_push = 1; md_nreq = 1; md_w = mword(int'(trig_ep)); m_state = 2;
          end
        end
      end else if (md_st0 == 2) begin
        md_first = -1;
        for (int i = 0; i < NE; i++) begin
          if (flit_in_wr_all[i] && cap_mask[i]) begin
            md_nreq++;
            if (md_first < 0) md_first = i;
          end
        end
        if (md_first >= 0) begin md_push = 1; md_w = mword(md_first); end
      end else begin
        if (arm && md_pre == 0) begin m_state = 1; m_hcnt = 0; m_drop = 0; end
      end
      md_ndrop = md_push ? md_nreq - 1 : 0;
      if (md_push && md_pre == DEPTH) begin md_ndrop = md_nreq; md_push = 0; end
      m_drop = (m_drop + md_ndrop > 65535) ? 65535 : m_drop + md_ndrop;
      if (md_st0 == 2 && md_push && !md_pop && md_pre == DEPTH - 1) m_state = 3;
      if (md_pop) void'(m_q.pop_front());
      if (md_push) m_q.push_back(md_w);
      m_ts = (m_ts + 1) % 65536;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("trigger", 32'(trigger), 32'(m_trig));
      chk("state_o", 32'(state_o), 32'(m_state));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("trace_valid", 32'(trace_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("trace_signal", trace_signal, m_q[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_flits();
    flit_in_all    = '0;
    flit_in_wr_all = '0;
  endtask

  task automatic put(input int ep, input bit hdr, input bit tail, input logic [7:0] pay);
    flit_in_all[ep*FW +: FW] = {hdr, tail, 28'd0, pay};
    flit_in_wr_all[ep] = 1'b1;
  endtask

  int pushes, nread, prev_ts, k;

  initial begin
    reset = 1; arm = 0; trig_ep = '0; trig_th = '0; cap_mask = '0; rd_en = 0;
    clr_flits();
    cyc(); cyc();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_valid", 32'(trace_valid), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_trigger", 32'(trigger), 0);
    chk("rst_signal", trace_signal, 0);
    reset = 0;

    // Trigger after two headers on ep3
    arm = 1; trig_ep = 6'd3; trig_th = 16'd2; cap_mask = 64'h0F;
    cyc(); arm = 0;
    chk("armed", 32'(state_o), 1);
    put(3, 1, 0, 8'hA1); cyc(); clr_flits();
    chk("no_trig_first_hdr", 32'(trigger), 0);
    put(3, 1, 0, 8'hA2); cyc(); clr_flits();
    chk("trig_pulse", 32'(trigger), 1);
    chk("trig_state", 32'(state_o), 2);
    chk("trig_word_ep", 32'(trace_signal[13:8]), 3);
    chk("trig_word_hdr", 32'(trace_signal[15]), 1);
    chk("trig_word_pay", 32'(trace_signal[7:0]), 32'h A2);
    cyc();
    chk("trig_one_cycle", 32'(trigger), 0);

    // ep1 and ep2 collide: ep1 kept, one drop
    put(1, 0, 0, 8'h11); put(2, 0, 1, 8'h22); cyc(); clr_flits();
    chk("collide_drop", 32'(drop_cnt), 1);
    rd_en = 1; cyc(); rd_en = 0;
    chk("collide_ep", 32'(trace_signal[13:8]), 1);
    chk("collide_pay", 32'(trace_signal[7:0]), 32'h11);

    // Fill the FIFO with ep0 writes
    pushes = 0;
    for (k = 0; k < 200; k++) begin
      put(0, 0, 0, 8'(k)); cyc(); clr_flits();
      pushes++;
      if (state_o == 2'd3) break;
    end
    chk("fill_pushes", 32'(pushes), 63);
    chk("fill_done", 32'(state_o), 3);
    put(0, 0, 0, 8'hEE); cyc(); clr_flits();
    arm = 1; cyc(); arm = 0;
    chk("arm_ignored_nonempty", 32'(state_o), 3);

    // Drain; ep0 words must carry consecutive timestamps
    nread = 0; prev_ts = -1;
    for (k = 0; k < 100 && trace_valid; k++) begin
      if (trace_signal[13:8] == 6'd0) begin
        if (prev_ts >= 0) chk("ts_consecutive", 32'(trace_signal[31:16]), 32'((prev_ts + 1) % 65536));
        prev_ts = int'(trace_signal[31:16]);
      end
      nread++;
      rd_en = 1; cyc(); rd_en = 0;
    end
    chk("drain_count", 32'(nread), 64);
    chk("drain_valid", 32'(trace_valid), 0);
    arm = 1; cyc(); arm = 0;
    chk("rearm_state", 32'(state_o), 1);
    chk("rearm_drop", 32'(drop_cnt), 0);

    // Threshold 0 fires on the first header
    trig_ep = 6'd5; trig_th = 16'd0; cap_mask = 64'h1;
    put(5, 1, 1, 8'h5A); cyc(); clr_flits();
    chk("th0_trigger", 32'(trigger), 1);
    chk("th0_ep", 32'(trace_signal[13:8]), 5);
    rd_en = 1; cyc(); rd_en = 0;

    // Timestamp wrap across two consecutive captures
    for (k = 0; k < 70000 && m_ts != 65535; k++) cyc();
    chk("ts_reach", 32'(m_ts), 32'd65535);
    put(0, 0, 0, 8'h55); cyc();
    put(0, 0, 0, 8'h66); cyc(); clr_flits();
    chk("wrap_ts_ffff", 32'(trace_signal[31:16]), 32'hFFFF);
    rd_en = 1; cyc(); rd_en = 0;
    chk("wrap_ts_0", 32'(trace_signal[31:16]), 0);
    chk("wrap_pay", 32'(trace_signal[7:0]), 32'h66);

    // Reset mid-capture with 10 words stored
    cap_mask = 64'h5;
    for (k = 0; k < 9; k++) begin
      put(0, 0, 0, 8'(k)); put(2, 0, 0, 8'(k)); cyc(); clr_flits();
    end
    chk("mid_drop", 32'(drop_cnt), 9);
    reset = 1; cyc(); reset = 0;
    chk("mid_rst_valid", 32'(trace_valid), 0);
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_drop", 32'(drop_cnt), 0);

    // Random traffic checked cycle by cycle
    for (int c = 0; c < 3000; c++) begin
      clr_flits();
      for (int e = 0; e < NE; e++) begin
        if ((e < 8) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0)) begin
          flit_in_all[e*FW +: FW] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                     4'($urandom), 32'($urandom)};
          flit_in_wr_all[e] = 1'b1;
        end
      end
      arm   = ($urandom_range(0, 15) == 0);
      rd_en = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) begin
        trig_ep  = 6'($urandom_range(0, 7));
        trig_th  = 16'($urandom_range(0, 3));
        cap_mask = {56'd0, 8'($urandom)};
      end
      cyc();
    end
    reset = 0; arm = 0; rd_en = 0; clr_flits();
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
